// File: rtl/rob_commit_unit_pkg.sv
// Shared types and constants for the ROB commit (retire) stage.
package rob_commit_unit_pkg;

  localparam int ADDR_WIDTH  = 32;
  localparam int PHY_WIDTH   = 6;
  localparam int FIFO_DEPTH  = 8;
  localparam int SQ_ID_WIDTH = $clog2(FIFO_DEPTH);
  localparam int CNT_WIDTH   = 32;

  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  // Sequential fall-through distance of one instruction.
  localparam logic [ADDR_WIDTH-1:0] PC_STEP = {{(ADDR_WIDTH-3){1'b0}}, 3'd4};

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    STORE_WAIT = 2'd1,
    FLUSH      = 2'd2
  } commit_state_t;

  typedef struct packed {
    logic                   valid;
    logic [6:0]             opcode;
    logic [4:0]             rd_arch;
    logic [PHY_WIDTH-1:0]   rd_phy_new;
    logic [PHY_WIDTH-1:0]   rd_phy_old;
    logic [SQ_ID_WIDTH-1:0] store_id;
    logic [ADDR_WIDTH-1:0]  update_pc;
    logic [ADDR_WIDTH-1:0]  actual_target;
    logic                   actual_taken;
    logic                   mispredict;
  } ROB_ENTRY_t;

  // Correct next fetch PC after a mispredicted control-flow entry (wraps naturally).
  function automatic logic [ADDR_WIDTH-1:0] redirect_target(input ROB_ENTRY_t e);
    logic [ADDR_WIDTH-1:0] pc;
    if (e.actual_taken) begin
      pc = e.actual_target;
    end else begin
      pc = e.update_pc + PC_STEP;
    end
    return pc;
  endfunction

endpackage

// File: rtl/rob_commit_unit_classify.sv
// Combinational opcode decode used by the commit stage.
module commit_classify
  import rob_commit_unit_pkg::*;
(
  input  logic [6:0] opcode,
  output logic       has_rd,
  output logic       is_cf,
  output logic       is_store
);

  // Classify the retiring opcode into destination / control-flow / store groups.
  always_comb begin
    has_rd   = 1'b0;
    is_cf    = 1'b0;
    is_store = 1'b0;
    case (opcode)
      OPC_OP, OPC_OPIMM, OPC_LOAD, OPC_LUI, OPC_AUIPC: begin
        has_rd = 1'b1;
      end
      OPC_JAL, OPC_JALR: begin
        has_rd = 1'b1;
        is_cf  = 1'b1;
      end
      OPC_BRANCH: begin
        is_cf = 1'b1;
      end
      OPC_STORE: begin
        is_store = 1'b1;
      end
      default: begin
        has_rd   = 1'b0;
        is_cf    = 1'b0;
        is_store = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/rob_commit_unit.sv
// Retire stage: pops the ROB head in order and broadcasts its architectural effects.
module rob_commit_unit
  import rob_commit_unit_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rob_head_valid,
  input  ROB_ENTRY_t             rob_head,
  output logic                   rob_head_ready,
  output logic                   free_valid,
  output logic [PHY_WIDTH-1:0]   free_phy,
  output logic                   amt_we,
  output logic [4:0]             amt_arch,
  output logic [PHY_WIDTH-1:0]   amt_phy,
  output logic                   btb_upd_valid,
  output logic [ADDR_WIDTH-1:0]  btb_upd_pc,
  output logic [ADDR_WIDTH-1:0]  btb_upd_target,
  output logic                   btb_upd_taken,
  output logic                   st_commit_valid,
  output logic [SQ_ID_WIDTH-1:0] st_commit_id,
  input  logic                   st_commit_ack,
  output logic                   flush,
  output logic                   redirect_valid,
  output logic [ADDR_WIDTH-1:0]  redirect_pc,
  output logic [CNT_WIDTH-1:0]   retire_count
);

  commit_state_t state_r;
  commit_state_t state_nxt_s;
  logic          has_rd_s;
  logic          is_cf_s;
  logic          is_store_s;
  logic          entry_ok_s;
  logic          pop_s;
  logic          start_store_s;
  logic          wr_rd_s;
  logic          mispop_s;

  commit_classify u_classify (
    .opcode   (rob_head.opcode),
    .has_rd   (has_rd_s),
    .is_cf    (is_cf_s),
    .is_store (is_store_s)
  );

  // Entries whose own valid bit is clear are malformed and never retire.
  assign entry_ok_s = rob_head_valid & rob_head.valid;
  assign wr_rd_s    = pop_s & has_rd_s & (rob_head.rd_arch != 5'd0);
  assign mispop_s   = pop_s & rob_head.mispredict;

  // Pop is suppressed while reset is held so every output reads zero.
  assign rob_head_ready = pop_s & rst_n;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and pop decision; a store only pops once the store queue acks it.
  always_comb begin
    state_nxt_s   = state_r;
    pop_s         = 1'b0;
    start_store_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (entry_ok_s && is_store_s) begin
          start_store_s = 1'b1;
          state_nxt_s   = STORE_WAIT;
        end else if (entry_ok_s) begin
          pop_s       = 1'b1;
          state_nxt_s = rob_head.mispredict ? FLUSH : IDLE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      STORE_WAIT: begin
        if (st_commit_ack) begin
          pop_s       = 1'b1;
          state_nxt_s = rob_head.mispredict ? FLUSH : IDLE;
        end else begin
          state_nxt_s = STORE_WAIT;
        end
      end
      FLUSH: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Registered one-cycle side effects of the entry popped in the previous cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      free_valid     <= 1'b0;
      free_phy       <= '0;
      amt_we         <= 1'b0;
      amt_arch       <= 5'd0;
      amt_phy        <= '0;
      btb_upd_valid  <= 1'b0;
      btb_upd_pc     <= '0;
      btb_upd_target <= '0;
      btb_upd_taken  <= 1'b0;
      flush          <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      retire_count   <= '0;
    end else begin
      free_valid     <= wr_rd_s;
      free_phy       <= wr_rd_s ? rob_head.rd_phy_old : '0;
      amt_we         <= wr_rd_s;
      amt_arch       <= wr_rd_s ? rob_head.rd_arch : 5'd0;
      amt_phy        <= wr_rd_s ? rob_head.rd_phy_new : '0;
      btb_upd_valid  <= pop_s & is_cf_s;
      btb_upd_pc     <= (pop_s & is_cf_s) ? rob_head.update_pc : '0;
      btb_upd_target <= (pop_s & is_cf_s) ? rob_head.actual_target : '0;
      btb_upd_taken  <= pop_s & is_cf_s & rob_head.actual_taken;
      flush          <= mispop_s;
      redirect_valid <= mispop_s;
      redirect_pc    <= mispop_s ? redirect_target(rob_head) : '0;
      retire_count   <= retire_count + {{(CNT_WIDTH-1){1'b0}}, pop_s};
    end
  end

  // Outstanding store-commit request, held stable until the store queue acks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_commit_valid <= 1'b0;
      st_commit_id    <= '0;
    end else if (start_store_s) begin
      st_commit_valid <= 1'b1;
      st_commit_id    <= rob_head.store_id;
    end else if ((state_r == STORE_WAIT) && st_commit_ack) begin
      st_commit_valid <= 1'b0;
      st_commit_id    <= st_commit_id;
    end else begin
      st_commit_valid <= st_commit_valid;
      st_commit_id    <= st_commit_id;
    end
  end

endmodule

// File: tb/tb_rob_commit_unit.sv
// Self-checking bench for rob_commit_unit: directed scenarios plus a randomized run against a retire model.
module tb_rob_commit_unit;
  import rob_commit_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rob_head_valid = 1'b0;
  ROB_ENTRY_t  rob_head = '0;
  logic        rob_head_ready;
  logic        free_valid;
  logic [5:0]  free_phy;
  logic        amt_we;
  logic [4:0]  amt_arch;
  logic [5:0]  amt_phy;
  logic        btb_upd_valid;
  logic [31:0] btb_upd_pc;
  logic [31:0] btb_upd_target;
  logic        btb_upd_taken;
  logic        st_commit_valid;
  logic [2:0]  st_commit_id;
  logic        st_commit_ack = 1'b0;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] retire_count;
  logic [155:0] all_out;

  int n_cmp = 0;
  int n_err = 0;

  rob_commit_unit dut (
    .clk(clk), .rst_n(rst_n), .rob_head_valid(rob_head_valid), .rob_head(rob_head),
    .rob_head_ready(rob_head_ready), .free_valid(free_valid), .free_phy(free_phy),
    .amt_we(amt_we), .amt_arch(amt_arch), .amt_phy(amt_phy),
    .btb_upd_valid(btb_upd_valid), .btb_upd_pc(btb_upd_pc), .btb_upd_target(btb_upd_target),
    .btb_upd_taken(btb_upd_taken), .st_commit_valid(st_commit_valid), .st_commit_id(st_commit_id),
    .st_commit_ack(st_commit_ack), .flush(flush), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .retire_count(retire_count)
  );

  assign all_out = {rob_head_ready, free_valid, free_phy, amt_we, amt_arch, amt_phy,
                    btb_upd_valid, btb_upd_pc, btb_upd_target, btb_upd_taken,
                    st_commit_valid, st_commit_id, flush, redirect_valid, redirect_pc, retire_count};

  always #5 clk = ~clk;

  function automatic ROB_ENTRY_t mk(input logic [6:0] op, input logic [4:0] rd,
                                    input logic [5:0] pn, input logic [5:0] po,
                                    input logic [2:0] sid, input logic [31:0] pc,
                                    input logic [31:0] tgt, input logic tk, input logic mp);
    ROB_ENTRY_t e;
    e.valid = 1'b1; e.opcode = op; e.rd_arch = rd; e.rd_phy_new = pn; e.rd_phy_old = po;
    e.store_id = sid; e.update_pc = pc; e.actual_target = tgt; e.actual_taken = tk; e.mispredict = mp;
    return e;
  endfunction

  // Reference classification from the instruction-set opcode groups.
  function automatic bit ref_has_rd(input logic [6:0] op);
    return op inside {7'h33, 7'h13, 7'h03, 7'h37, 7'h17, 7'h6F, 7'h67};
  endfunction
  function automatic bit ref_is_cf(input logic [6:0] op);
    return op inside {7'h63, 7'h6F, 7'h67};
  endfunction

  task automatic apply_reset();
    rst_n = 1'b0; rob_head_valid = 1'b0; st_commit_ack = 1'b0; rob_head = '0;
    @(posedge clk); #1;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rob_head_valid = 1'b1; rob_head = mk(7'h33, 5'd1, 6'd2, 6'd3, 3'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    #3;
    n_cmp++; if (all_out !== 156'd0) begin n_err++; $display("FAIL reset_outputs: got %h want 0", all_out); end
    @(negedge clk); rst_n = 1'b1; rob_head_valid = 1'b0;
  endtask

  task automatic test_alu_retire();
    apply_reset();
    @(posedge clk); #1; rob_head_valid = 1'b1; rob_head = mk(7'h33, 5'd5, 6'd40, 6'd12, 3'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    n_cmp++; if (rob_head_ready !== 1'b1) begin n_err++; $display("FAIL alu_ready: got %b want 1", rob_head_ready); end
    @(posedge clk); #1; rob_head_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if ({amt_we, amt_arch, amt_phy, free_valid, free_phy} !== {1'b1, 5'd5, 6'd40, 1'b1, 6'd12})
      begin n_err++; $display("FAIL alu_effects: got we=%b arch=%0d phy=%0d fv=%b fp=%0d want 1/5/40/1/12", amt_we, amt_arch, amt_phy, free_valid, free_phy); end
    n_cmp++; if (retire_count !== 32'd1) begin n_err++; $display("FAIL alu_count: got %0d want 1", retire_count); end
    n_cmp++; if ({btb_upd_valid, flush, redirect_valid} !== 3'b000) begin n_err++; $display("FAIL alu_no_cf: got %b want 000", {btb_upd_valid, flush, redirect_valid}); end
    @(posedge clk); #1; @(negedge clk);
    n_cmp++; if ({amt_we, free_valid} !== 2'b00) begin n_err++; $display("FAIL alu_pulse_once: got %b want 00", {amt_we, free_valid}); end
  endtask

  task automatic test_x0();
    apply_reset();
    @(posedge clk); #1; rob_head_valid = 1'b1; rob_head = mk(7'h13, 5'd0, 6'd7, 6'd9, 3'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    n_cmp++; if (rob_head_ready !== 1'b1) begin n_err++; $display("FAIL x0_ready: got %b want 1", rob_head_ready); end
    @(posedge clk); #1; rob_head_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if ({amt_we, free_valid} !== 2'b00) begin n_err++; $display("FAIL x0_no_write: got %b want 00", {amt_we, free_valid}); end
    n_cmp++; if (retire_count !== 32'd1) begin n_err++; $display("FAIL x0_count: got %0d want 1", retire_count); end
  endtask

  task automatic test_store_ack();
    apply_reset();
    @(posedge clk); #1; rob_head_valid = 1'b1; rob_head = mk(7'h23, 5'd4, 6'd1, 6'd2, 3'd3, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    n_cmp++; if (rob_head_ready !== 1'b0) begin n_err++; $display("FAIL store_first_ready: got %b want 0", rob_head_ready); end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1; @(negedge clk);
      n_cmp++; if ({st_commit_valid, st_commit_id, rob_head_ready} !== {1'b1, 3'd3, 1'b0})
        begin n_err++; $display("FAIL store_wait[%0d]: got v=%b id=%0d rdy=%b want 1/3/0", i, st_commit_valid, st_commit_id, rob_head_ready); end
    end
    @(posedge clk); #1; st_commit_ack = 1'b1;
    @(negedge clk);
    n_cmp++; if (rob_head_ready !== 1'b1) begin n_err++; $display("FAIL store_ack_pop: got %b want 1", rob_head_ready); end
    @(posedge clk); #1; st_commit_ack = 1'b0; rob_head_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if ({st_commit_valid, amt_we, free_valid} !== 3'b000) begin n_err++; $display("FAIL store_release: got %b want 000", {st_commit_valid, amt_we, free_valid}); end
    n_cmp++; if (retire_count !== 32'd1) begin n_err++; $display("FAIL store_count: got %0d want 1", retire_count); end
  endtask

  task automatic test_mispredict_taken();
    apply_reset();
    @(posedge clk); #1; rob_head_valid = 1'b1; rob_head = mk(7'h63, 5'd0, 6'd0, 6'd0, 3'd0, 32'h100, 32'h200, 1'b1, 1'b1);
    @(negedge clk);
    n_cmp++; if (rob_head_ready !== 1'b1) begin n_err++; $display("FAIL br_ready: got %b want 1", rob_head_ready); end
    @(posedge clk); #1; rob_head = mk(7'h33, 5'd6, 6'd3, 6'd4, 3'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    n_cmp++; if ({btb_upd_valid, btb_upd_pc, btb_upd_target, btb_upd_taken} !== {1'b1, 32'h100, 32'h200, 1'b1})
      begin n_err++; $display("FAIL br_btb: got v=%b pc=%h tgt=%h tk=%b want 1/100/200/1", btb_upd_valid, btb_upd_pc, btb_upd_target, btb_upd_taken); end
    n_cmp++; if ({flush, redirect_valid, redirect_pc} !== {1'b1, 1'b1, 32'h200})
      begin n_err++; $display("FAIL br_redirect: got fl=%b rv=%b pc=%h want 1/1/200", flush, redirect_valid, redirect_pc); end
    n_cmp++; if (rob_head_ready !== 1'b0) begin n_err++; $display("FAIL br_bubble: got %b want 0", rob_head_ready); end
    @(posedge clk); #1; @(negedge clk);
    n_cmp++; if ({flush, rob_head_ready} !== 2'b01) begin n_err++; $display("FAIL br_resume: got %b want 01", {flush, rob_head_ready}); end
    @(posedge clk); #1; rob_head_valid = 1'b0;
  endtask

  task automatic test_mispredict_wrap();
    apply_reset();
    @(posedge clk); #1; rob_head_valid = 1'b1; rob_head = mk(7'h63, 5'd0, 6'd0, 6'd0, 3'd0, 32'hFFFF_FFFC, 32'h40, 1'b0, 1'b1);
    @(negedge clk);
    @(posedge clk); #1; rob_head_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if ({flush, redirect_valid, redirect_pc} !== {1'b1, 1'b1, 32'h0})
      begin n_err++; $display("FAIL wrap_redirect: got fl=%b rv=%b pc=%h want 1/1/0", flush, redirect_valid, redirect_pc); end
    n_cmp++; if (btb_upd_taken !== 1'b0) begin n_err++; $display("FAIL wrap_taken: got %b want 0", btb_upd_taken); end
  endtask

  task automatic test_back_to_back();
    int pops = 0;
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1; rob_head_valid = 1'b1;
      rob_head = mk(7'h33, 5'(i + 1), 6'(i + 20), 6'(i + 30), 3'd0, 32'h0, 32'h0, 1'b0, 1'b0);
      @(negedge clk);
      if (rob_head_ready === 1'b1) pops++;
    end
    n_cmp++; if (pops != 8) begin n_err++; $display("FAIL b2b_pops: got %0d want 8", pops); end
    @(posedge clk); #1; rob_head_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if ({retire_count, amt_arch, amt_phy} !== {32'd8, 5'd8, 6'd27})
      begin n_err++; $display("FAIL b2b_count: got cnt=%0d arch=%0d phy=%0d want 8/8/27", retire_count, amt_arch, amt_phy); end
    // Reset in the middle of a stream of valid entries.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1; rob_head_valid = 1'b1;
      rob_head = mk(7'h13, 5'd9, 6'd10, 6'd11, 3'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    end
    #1; rst_n = 1'b0; #1;
    n_cmp++; if (all_out !== 156'd0) begin n_err++; $display("FAIL midreset_outputs: got %h want 0", all_out); end
    @(negedge clk); rst_n = 1'b1; rob_head_valid = 1'b0;
    // Reset while waiting on a store ack abandons the request.
    @(posedge clk); #1; rob_head_valid = 1'b1; rob_head = mk(7'h23, 5'd0, 6'd0, 6'd0, 3'd5, 32'h0, 32'h0, 1'b0, 1'b0);
    @(posedge clk); #1; @(posedge clk); #1;
    n_cmp++; if ({st_commit_valid, st_commit_id} !== {1'b1, 3'd5}) begin n_err++; $display("FAIL st_pending: got %b/%0d want 1/5", st_commit_valid, st_commit_id); end
    rst_n = 1'b0; #1;
    n_cmp++; if (st_commit_valid !== 1'b0) begin n_err++; $display("FAIL st_abandon: got %b want 0", st_commit_valid); end
    @(negedge clk); rst_n = 1'b1; rob_head_valid = 1'b0;
  endtask

  task automatic test_random();
    localparam int N = 80;
    logic [6:0] ops [10] = '{7'h33, 7'h13, 7'h03, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h23, 7'h73};
    ROB_ENTRY_t prog [$];
    ROB_ENTRY_t he, prev_e;
    int idx = 0, cycles = 0;
    int unsigned mcount = 0;
    bit prev_pop = 0, bubble = 0, store_wait = 0, new_bubble, exp_ready, hv, is_st, exp_we, exp_btb, exp_fl;
    logic [2:0]  sid_exp = 3'd0;
    logic [31:0] exp_rpc;
    prev_e = '0;
    for (int i = 0; i < N; i++) begin
      ROB_ENTRY_t e;
      e = mk(ops[$urandom_range(0, 9)], 5'($urandom_range(0, 31)), 6'($urandom), 6'($urandom),
             3'($urandom), {$urandom, 2'b00} , $urandom, 1'($urandom), 1'b0);
      if ($urandom_range(0, 5) == 0) e.rd_arch = 5'd0;
      if (ref_is_cf(e.opcode) && ($urandom_range(0, 2) == 0)) e.mispredict = 1'b1;
      if ($urandom_range(0, 7) == 0) e.update_pc = 32'hFFFF_FFFC;
      prog.push_back(e);
    end
    apply_reset();
    while (idx < N && cycles < 3000) begin
      @(posedge clk); #1;
      he = prog[idx];
      if (store_wait) begin
        hv = 1'b1; st_commit_ack = ($urandom_range(0, 2) == 0);
      end else begin
        hv = ($urandom_range(0, 4) != 0); st_commit_ack = 1'b0;
        if ($urandom_range(0, 7) == 0) he.valid = 1'b0;
      end
      rob_head_valid = hv; rob_head = he;
      is_st = (he.opcode == 7'h23);
      if (bubble) exp_ready = 1'b0;
      else if (store_wait) exp_ready = st_commit_ack;
      else exp_ready = hv && he.valid && !is_st;
      @(negedge clk);
      n_cmp++; if (rob_head_ready !== exp_ready) begin n_err++; $display("FAIL rnd_ready@%0d: got %b want %b", cycles, rob_head_ready, exp_ready); end
      exp_we = prev_pop && ref_has_rd(prev_e.opcode) && (prev_e.rd_arch != 5'd0);
      n_cmp++; if ({amt_we, free_valid} !== {exp_we, exp_we}) begin n_err++; $display("FAIL rnd_we@%0d: got %b%b want %b", cycles, amt_we, free_valid, exp_we); end
      if (exp_we) begin
        n_cmp++; if ({amt_arch, amt_phy, free_phy} !== {prev_e.rd_arch, prev_e.rd_phy_new, prev_e.rd_phy_old})
          begin n_err++; $display("FAIL rnd_map@%0d: got %0d/%0d/%0d want %0d/%0d/%0d", cycles, amt_arch, amt_phy, free_phy, prev_e.rd_arch, prev_e.rd_phy_new, prev_e.rd_phy_old); end
      end
      exp_btb = prev_pop && ref_is_cf(prev_e.opcode);
      n_cmp++; if (btb_upd_valid !== exp_btb) begin n_err++; $display("FAIL rnd_btb_v@%0d: got %b want %b", cycles, btb_upd_valid, exp_btb); end
      if (exp_btb) begin
        n_cmp++; if ({btb_upd_pc, btb_upd_target, btb_upd_taken} !== {prev_e.update_pc, prev_e.actual_target, prev_e.actual_taken})
          begin n_err++; $display("FAIL rnd_btb@%0d: got %h/%h/%b want %h/%h/%b", cycles, btb_upd_pc, btb_upd_target, btb_upd_taken, prev_e.update_pc, prev_e.actual_target, prev_e.actual_taken); end
      end
      exp_fl = prev_pop && prev_e.mispredict;
      n_cmp++; if ({flush, redirect_valid} !== {exp_fl, exp_fl}) begin n_err++; $display("FAIL rnd_flush@%0d: got %b%b want %b", cycles, flush, redirect_valid, exp_fl); end
      if (exp_fl) begin
        exp_rpc = prev_e.actual_taken ? prev_e.actual_target : prev_e.update_pc + 32'd4;
        n_cmp++; if (redirect_pc !== exp_rpc) begin n_err++; $display("FAIL rnd_rpc@%0d: got %h want %h", cycles, redirect_pc, exp_rpc); end
      end
      n_cmp++; if (st_commit_valid !== store_wait) begin n_err++; $display("FAIL rnd_stv@%0d: got %b want %b", cycles, st_commit_valid, store_wait); end
      if (store_wait) begin
        n_cmp++; if (st_commit_id !== sid_exp) begin n_err++; $display("FAIL rnd_stid@%0d: got %0d want %0d", cycles, st_commit_id, sid_exp); end
      end
      n_cmp++; if (retire_count !== mcount) begin n_err++; $display("FAIL rnd_count@%0d: got %0d want %0d", cycles, retire_count, mcount); end
      prev_pop = exp_ready; prev_e = he;
      if (exp_ready) begin mcount++; idx++; end
      new_bubble = exp_ready && he.mispredict;
      if (store_wait) begin
        if (st_commit_ack) store_wait = 1'b0;
      end else if (!bubble && hv && he.valid && is_st) begin
        store_wait = 1'b1; sid_exp = he.store_id;
      end
      bubble = new_bubble;
      cycles++;
    end
    n_cmp++; if (idx < N) begin n_err++; $display("FAIL rnd_timeout: retired %0d want %0d", idx, N); end
    @(posedge clk); #1; rob_head_valid = 1'b0; st_commit_ack = 1'b0;
    @(negedge clk);
    n_cmp++; if (retire_count !== mcount) begin n_err++; $display("FAIL rnd_final_count: got %0d want %0d", retire_count, mcount); end
  endtask

  initial begin
    test_reset();
    test_alu_retire();
    test_x0();
    test_store_ack();
    test_mispredict_taken();
    test_mispredict_wrap();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
